// File: rtl/m2_write_s_if.sv
// Write-S bus bundle: start/done control, S DPRAM read ports, SRAM write port,
// clip statistics and the FSM state for observation.
// The DUT side uses the slave modport; the parent (or bench) uses master.
interface m2_write_s_if;
  logic        WS_start;
  logic        WS_done;
  logic        WS_frame_done;
  logic [6:0]  S_address_a;
  logic [6:0]  S_address_b;
  logic [31:0] S_read_data_a;
  logic [31:0] S_read_data_b;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] WS_clip_count;
  logic [1:0]  ws_state;

  modport slave (
    input  WS_start, S_read_data_a, S_read_data_b,
    output WS_done, WS_frame_done, S_address_a, S_address_b,
           SRAM_address, SRAM_write_data, SRAM_we_n, WS_clip_count, ws_state
  );

  modport master (
    output WS_start, S_read_data_a, S_read_data_b,
    input  WS_done, WS_frame_done, S_address_a, S_address_b,
           SRAM_address, SRAM_write_data, SRAM_we_n, WS_clip_count, ws_state
  );
endinterface

// File: rtl/m2_write_s.sv
// Milestone 2 IDCT write-back stage ("Write S").
// Reads one 8x8 block of S values from the S DPRAM, clips each to 8 bits,
// packs two pixels per word and writes 32 words into the Y/U/V segments.
// Block position counters walk Y, then U, then V, then wrap.
// Optional macro WS_CLIP_STATS_EN enables the saturating clipped-pixel counter.
//
// Handshake: WS_start is a level; a block begins on its rising edge seen in
// S_WS_IDLE only (edges elsewhere are dropped). WS_done pulses for one cycle
// when the block's last write has retired and SRAM_we_n is back high;
// WS_frame_done pulses with it on the last V block of a frame.
module m2_write_s #(
  parameter logic [17:0] Y_BASE        = 18'd0,
  parameter logic [17:0] U_BASE        = 18'd38400,
  parameter logic [17:0] V_BASE        = 18'd57600,
  parameter logic [17:0] Y_STRIDE      = 18'd160,
  parameter logic [17:0] UV_STRIDE     = 18'd80,
  parameter logic [5:0]  Y_COL_BLOCKS  = 6'd40,
  parameter logic [5:0]  UV_COL_BLOCKS = 6'd20,
  parameter logic [4:0]  ROW_BLOCKS    = 5'd30
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  m2_write_s_if.slave ws
);

  typedef enum logic [1:0] {S_WS_IDLE, S_WS_LI, S_WS_RUN, S_WS_LO} ws_state_t;
  typedef enum logic [1:0] {SEG_Y, SEG_U, SEG_V} seg_t;

  ws_state_t   state, state_n;
  seg_t        seg;
  logic [4:0]  rb;
  logic [5:0]  cb;
  logic [4:0]  k;
  logic        start_q;
  logic        start_cond;
  logic [17:0] seg_base;
  logic [17:0] stride;
  logic [5:0]  col_blocks;
  logic [7:0]  row_idx;
  logic [17:0] addr_calc;
  logic        last_block;

  function automatic logic [7:0] clip8(input logic [31:0] v);
    if (v[31])          return 8'd0;
    else if (|v[30:8])  return 8'd255;
    else                return v[7:0];
  endfunction

  assign start_cond  = ws.WS_start & ~start_q;
  assign ws.ws_state = state;

  // Segment-dependent geometry and the SRAM word address of word k.
  always_comb begin
    seg_base   = Y_BASE;
    stride     = Y_STRIDE;
    col_blocks = Y_COL_BLOCKS;
    case (seg)
      SEG_U: begin seg_base = U_BASE; stride = UV_STRIDE; col_blocks = UV_COL_BLOCKS; end
      SEG_V: begin seg_base = V_BASE; stride = UV_STRIDE; col_blocks = UV_COL_BLOCKS; end
      default: ;
    endcase
    row_idx    = {rb, 3'b000} + {5'd0, k[4:2]};
    addr_calc  = seg_base + ({10'd0, row_idx} * stride) + {10'd0, cb, 2'b00} + {16'd0, k[1:0]};
    last_block = (seg == SEG_V) && (rb == ROW_BLOCKS - 5'd1) && (cb == col_blocks - 6'd1);
  end

  // State register and start-edge history.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state   <= S_WS_IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_n;
      start_q <= ws.WS_start;
    end
  end

  // Next state and DPRAM read addresses; data arrives one clock later.
  always_comb begin
    state_n        = state;
    ws.S_address_a = 7'd0;
    ws.S_address_b = 7'd0;
    case (state)
      S_WS_IDLE: if (start_cond) state_n = S_WS_LI;
      S_WS_LI: begin
        ws.S_address_a = 7'd0;
        ws.S_address_b = 7'd1;
        state_n        = S_WS_RUN;
      end
      S_WS_RUN: begin
        ws.S_address_a = {1'b0, k, 1'b0} + 7'd2;
        ws.S_address_b = {1'b0, k, 1'b0} + 7'd3;
        if (k == 5'd31) state_n = S_WS_LO;
      end
      S_WS_LO:  state_n = S_WS_IDLE;
      default:  state_n = S_WS_IDLE;
    endcase
  end

  // Word index within the block.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn)                k <= 5'd0;
    else if (state == S_WS_LI)  k <= 5'd0;
    else if (state == S_WS_RUN) k <= k + 5'd1;
  end

  // Registered SRAM write port and completion pulses.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      ws.SRAM_address    <= 18'd0;
      ws.SRAM_write_data <= 16'd0;
      ws.SRAM_we_n       <= 1'b1;
      ws.WS_done         <= 1'b0;
      ws.WS_frame_done   <= 1'b0;
    end else begin
      ws.WS_done       <= 1'b0;
      ws.WS_frame_done <= 1'b0;
      ws.SRAM_we_n     <= 1'b1;
      if (state == S_WS_RUN) begin
        ws.SRAM_we_n       <= 1'b0;
        ws.SRAM_address    <= addr_calc;
        ws.SRAM_write_data <= {clip8(ws.S_read_data_a), clip8(ws.S_read_data_b)};
      end else if (state == S_WS_LO) begin
        ws.WS_done       <= 1'b1;
        ws.WS_frame_done <= last_block;
      end
    end
  end

  // Block position: column, then row, then segment; wraps to Y block 0.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      seg <= SEG_Y;
      rb  <= 5'd0;
      cb  <= 6'd0;
    end else if (state == S_WS_LO) begin
      if (cb == col_blocks - 6'd1) begin
        cb <= 6'd0;
        if (rb == ROW_BLOCKS - 5'd1) begin
          rb <= 5'd0;
          case (seg)
            SEG_Y:   seg <= SEG_U;
            SEG_U:   seg <= SEG_V;
            default: seg <= SEG_Y;
          endcase
        end else begin
          rb <= rb + 5'd1;
        end
      end else begin
        cb <= cb + 6'd1;
      end
    end
  end

`ifdef WS_CLIP_STATS_EN
  logic        fl_a, fl_b;
  logic [15:0] clip_inc;
  logic [15:0] clip_cnt;

  assign fl_a     = ws.S_read_data_a[31] | (|ws.S_read_data_a[30:8]);
  assign fl_b     = ws.S_read_data_b[31] | (|ws.S_read_data_b[30:8]);
  assign clip_inc = {15'd0, fl_a} + {15'd0, fl_b};

  // Saturating count of clipped pixels over all RUN cycles since reset.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      clip_cnt <= 16'd0;
    end else if (state == S_WS_RUN) begin
      if (clip_cnt > 16'hFFFF - clip_inc) clip_cnt <= 16'hFFFF;
      else                                clip_cnt <= clip_cnt + clip_inc;
    end
  end

  assign ws.WS_clip_count = clip_cnt;
`else
  assign ws.WS_clip_count = 16'd0;
`endif

endmodule

// File: tb/tb_m2_write_s.sv
// Directed bench for m2_write_s: ramp block, clipping, block progression
// through Y/U/V, frame wrap, start-level handshake and mid-block reset.
module tb_m2_write_s;

`ifdef WS_CLIP_STATS_EN
  localparam int CLIP_EXP = 3;
`else
  localparam int CLIP_EXP = 0;
`endif

  logic clk;
  logic rstn;
  int   cmp_cnt = 0;
  int   fail_cnt = 0;
  int   cyc = 0;

  logic [31:0] s_mem [64];

  int          wr_cnt = 0;
  logic [17:0] wr_addr [64];
  logic [15:0] wr_data [64];
  int          first_wr_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          frame_cnt = 0;
  int          start_cyc = 0;
  logic        last_frame;

  m2_write_s_if bus ();

  m2_write_s dut (
    .CLOCK_50_I (clk),
    .Resetn     (rstn),
    .ws         (bus.slave)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // S DPRAM model with one-clock read latency.
  always @(posedge clk) begin
    bus.S_read_data_a <= (bus.S_address_a < 7'd64) ? s_mem[bus.S_address_a[5:0]] : 32'h0;
    bus.S_read_data_b <= (bus.S_address_b < 7'd64) ? s_mem[bus.S_address_b[5:0]] : 32'h0;
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!bus.SRAM_we_n) begin
      if (wr_cnt < 64) begin
        wr_addr[wr_cnt] = bus.SRAM_address;
        wr_data[wr_cnt] = bus.SRAM_write_data;
      end
      if (wr_cnt == 0) first_wr_cyc = cyc;
      wr_cnt++;
    end
    if (bus.WS_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.WS_frame_done) frame_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One start pulse, then wait (bounded) for WS_done.
  task automatic run_block();
    int  d0;
    bit  ok;
    d0 = done_cnt;
    wr_cnt = 0;
    bus.WS_start = 1'b1;
    step();
    start_cyc = cyc;
    bus.WS_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (done_cnt != d0) ok = 1'b1;
    end
    last_frame = bus.WS_frame_done;
    check("block_done_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) s_mem[i] = 32'(i);
  endtask

  initial begin
    int d0;
    bit hit;
    rstn = 1'b0;
    bus.WS_start = 1'b0;
    fill_ramp();
    repeat (3) step();

    // Reset state.
    check("rst_we_n", {31'd0, bus.SRAM_we_n}, 32'd1);
    check("rst_addr", {14'd0, bus.SRAM_address}, 32'd0);
    check("rst_data", {16'd0, bus.SRAM_write_data}, 32'd0);
    check("rst_done", {30'd0, bus.WS_done, bus.WS_frame_done}, 32'd0);
    check("rst_clip", {16'd0, bus.WS_clip_count}, 32'd0);
    check("rst_state", {30'd0, bus.ws_state}, 32'd0);
    rstn = 1'b1;
    step();

    // Ramp block: Y block 0.
    run_block();
    check("ramp_wr_cnt", 32'(wr_cnt), 32'd32);
    check("ramp_first_lat", 32'(first_wr_cyc - start_cyc), 32'd2);
    check("ramp_done_lat", 32'(done_cyc - start_cyc), 32'd34);
    check("ramp_word0", {16'd0, wr_data[0]}, 32'h0001);
    check("ramp_word31", {16'd0, wr_data[31]}, 32'h3E3F);
    for (int k = 0; k < 32; k++) begin
      check("ramp_addr", {14'd0, wr_addr[k]}, 32'((k / 4) * 160 + (k % 4)));
      check("ramp_data", {16'd0, wr_data[k]}, 32'((2 * k) * 256 + 2 * k + 1));
    end
    check("ramp_we_n_after", {31'd0, bus.SRAM_we_n}, 32'd1);
    check("ramp_clip", {16'd0, bus.WS_clip_count}, 32'd0);

    // Clip block: Y block 1.
    s_mem[0] = -32'sd5;
    s_mem[1] = 32'd300;
    s_mem[2] = 32'd255;
    s_mem[3] = 32'h8000_0000;
    run_block();
    check("clip_word0", {16'd0, wr_data[0]}, 32'h00FF);
    check("clip_word1", {16'd0, wr_data[1]}, 32'hFF00);
    check("clip_addr0", {14'd0, wr_addr[0]}, 32'd4);
    check("clip_count", {16'd0, bus.WS_clip_count}, 32'(CLIP_EXP));
    fill_ramp();

    // Handshake: start held high for 100 clocks gives exactly one block.
    d0 = done_cnt;
    wr_cnt = 0;
    bus.WS_start = 1'b1;
    repeat (100) step();
    bus.WS_start = 1'b0;
    repeat (5) step();
    check("hold_wr_cnt", 32'(wr_cnt), 32'd32);
    check("hold_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("hold_addr0", {14'd0, wr_addr[0]}, 32'd8);

    // Reset in the middle of a block (Y block 3 would start at 12).
    wr_cnt = 0;
    bus.WS_start = 1'b1;
    step();
    bus.WS_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (wr_cnt == 11) hit = 1'b1;
    end
    check("midrst_reached_k10", {31'd0, hit}, 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst_we_n", {31'd0, bus.SRAM_we_n}, 32'd1);
    check("midrst_addr", {14'd0, bus.SRAM_address}, 32'd0);
    check("midrst_state", {30'd0, bus.ws_state}, 32'd0);
    step();
    rstn = 1'b1;
    step();
    run_block();
    check("after_rst_addr0", {14'd0, wr_addr[0]}, 32'd0);
    check("after_rst_addr31", {14'd0, wr_addr[31]}, 32'd1123);
    check("after_rst_word31", {16'd0, wr_data[31]}, 32'h3E3F);

    // Progression through a whole frame and the wrap.
    frame_cnt = 0;
    for (int b = 1; b <= 2400; b++) begin
      run_block();
      case (b)
        40:   check("blk40_addr", {14'd0, wr_addr[0]}, 32'd1280);
        1199: check("blk1199_addr", {14'd0, wr_addr[0]}, 32'd37276);
        1200: check("blk1200_addr", {14'd0, wr_addr[0]}, 32'd38400);
        1201: check("blk1201_addr", {14'd0, wr_addr[0]}, 32'd38404);
        1800: check("blk1800_addr", {14'd0, wr_addr[0]}, 32'd57600);
        2398: check("frame_cnt_early", 32'(frame_cnt), 32'd0);
        2399: begin
          check("blk2399_addr", {14'd0, wr_addr[0]}, 32'd76236);
          check("frame_with_done", {31'd0, last_frame}, 32'd1);
          check("frame_cnt", 32'(frame_cnt), 32'd1);
        end
        2400: begin
          check("wrap_addr0", {14'd0, wr_addr[0]}, 32'd0);
          check("wrap_no_frame", {31'd0, last_frame}, 32'd0);
        end
        default: ;
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
